// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, mtimecmp compare and sticky interrupt.
// Build option: define MMIO_TIMER_AUTO_RELOAD_EN for CTRL.auto_reload and the PERIOD register.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        timer_interrupt
);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_PRESCALE = 3'd5;
  localparam logic [2:0] IDX_STATUS   = 3'd6;
  localparam logic [2:0] IDX_PERIOD   = 3'd7;

  logic                  hit;
  logic                  wr_ok;
  logic [2:0]            idx;
  logic                  wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic                  wr_ctrl, wr_prescale, wr_status;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  en;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pscnt;
  logic                  pending;
  logic                  cmp_prev;
  logic                  cmp_now;
  logic                  cmp_event;
  logic                  tick;
  logic [31:0]           ctrl_rd;
  logic [31:0]           period_rd;

  assign hit   = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
  assign sel   = hit & (rd_en | wr_en);
  assign wr_ok = wr_en & hit & (mem_acc_mode == 3'b010);
  assign idx   = addr[4:2];

  assign wr_mtime_lo = wr_ok && (idx == IDX_MTIME_LO);
  assign wr_mtime_hi = wr_ok && (idx == IDX_MTIME_HI);
  assign wr_cmp_lo   = wr_ok && (idx == IDX_CMP_LO);
  assign wr_cmp_hi   = wr_ok && (idx == IDX_CMP_HI);
  assign wr_ctrl     = wr_ok && (idx == IDX_CTRL);
  assign wr_prescale = wr_ok && (idx == IDX_PRESCALE);
  assign wr_status   = wr_ok && (idx == IDX_STATUS);

  assign tick      = en && (pscnt == '0);
  assign cmp_now   = (mtime >= mtimecmp);
  assign cmp_event = cmp_now & ~cmp_prev;

  // Only registered state feeds the interrupt, so it cannot glitch on bus activity.
  assign timer_interrupt = pending & irq_en;

`ifdef MMIO_TIMER_AUTO_RELOAD_EN
  logic        auto_reload;
  logic [31:0] period;
  logic        wr_period;

  assign wr_period = wr_ok && (idx == IDX_PERIOD);
  assign ctrl_rd   = {29'h0, auto_reload, irq_en, en};
  assign period_rd = period;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_reload <= 1'b0;
      period      <= '0;
    end else begin
      if (wr_ctrl)   auto_reload <= wdata[2];
      if (wr_period) period      <= wdata;
    end
  end
`else
  assign ctrl_rd   = {30'h0, irq_en, en};
  assign period_rd = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      pscnt    <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= wdata[0];
        irq_en <= wdata[1];
      end
      if (wr_prescale) prescale <= wdata[PRESCALE_W-1:0];
      if (wr_prescale)  pscnt <= wdata[PRESCALE_W-1:0];
      else if (tick)    pscnt <= prescale;
      else if (en)      pscnt <= pscnt - PRESCALE_W'(1);
    end
  end

  // A software write to either half wins over the tick; the increment is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= wdata;
`ifdef MMIO_TIMER_AUTO_RELOAD_EN
    end else if (cmp_event && auto_reload) begin
      mtimecmp <= mtimecmp + {32'h0, period};
`endif
    end
  end

  // Clearing cmp_prev on a compare write re-arms the edge detector for the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      cmp_prev <= (wr_cmp_lo || wr_cmp_hi) ? 1'b0 : cmp_now;
      if (cmp_event)                   pending <= 1'b1;
      else if (wr_status && wdata[0])  pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd_en && hit) begin
      case (idx)
        IDX_MTIME_LO: rdata = mtime[31:0];
        IDX_MTIME_HI: rdata = mtime[63:32];
        IDX_CMP_LO:   rdata = mtimecmp[31:0];
        IDX_CMP_HI:   rdata = mtimecmp[63:32];
        IDX_CTRL:     rdata = ctrl_rd;
        IDX_PRESCALE: rdata = 32'(prescale);
        IDX_STATUS:   rdata = {31'h0, pending};
        IDX_PERIOD:   rdata = period_rd;
        default:      rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: expectations queued per bus cycle and checked mid-cycle.
module tb_mmio_timer;

  localparam logic [31:0] B    = 32'h8000_0000;
  localparam logic [31:0] MLO  = B + 32'h00;
  localparam logic [31:0] MHI  = B + 32'h04;
  localparam logic [31:0] CLO  = B + 32'h08;
  localparam logic [31:0] CHI  = B + 32'h0C;
  localparam logic [31:0] CTRL = B + 32'h10;
  localparam logic [31:0] PS   = B + 32'h14;
  localparam logic [31:0] ST   = B + 32'h18;
  localparam logic [31:0] PER  = B + 32'h1C;
  localparam logic [2:0]  WORD = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  mem_acc_mode;
  logic        sel, timer_interrupt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 rdata, 1 timer_interrupt, 2 sel
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  mmio_timer dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .mem_acc_mode(mem_acc_mode), .wdata(wdata), .rdata(rdata), .sel(sel),
    .timer_interrupt(timer_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  // One bus cycle: drive after the edge, score mid-cycle, release after the next edge.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [2:0] m, input logic [31:0] d);
    sb_t e;
    rd_en = r; wr_en = w; addr = a; mem_acc_mode = m; wdata = d;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       chk(e.tag, rdata, e.exp);
        1:       chk(e.tag, {31'h0, timer_interrupt}, e.exp);
        default: chk(e.tag, {31'h0, sel}, e.exp);
      endcase
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_acc_mode = WORD; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    push(tag, 0, exp);
    push({tag, "_sel"}, 2, 32'h1);
    cyc(1'b1, 1'b0, a, WORD, 32'h0);
  endtask

  task automatic rd_raw(input logic [31:0] a, input logic [2:0] m, input logic [31:0] exp,
                        input logic exp_sel, input string tag);
    push(tag, 0, exp);
    push({tag, "_sel"}, 2, {31'h0, exp_sel});
    cyc(1'b1, 1'b0, a, m, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, WORD, d);
  endtask

  task automatic exp_irq(input logic e, input string tag);
    push(tag, 1, {31'h0, e});
  endtask

  task automatic check_reset_state(input string pfx);
    rd(MLO,  32'h0,         {pfx, "_mtime_lo"});
    rd(MHI,  32'h0,         {pfx, "_mtime_hi"});
    rd(CLO,  32'hFFFF_FFFF, {pfx, "_cmp_lo"});
    rd(CHI,  32'hFFFF_FFFF, {pfx, "_cmp_hi"});
    rd(CTRL, 32'h0,         {pfx, "_ctrl"});
    rd(PS,   32'h0,         {pfx, "_prescale"});
    rd(PER,  32'h0,         {pfx, "_period"});
    exp_irq(1'b0, {pfx, "_irq"});
    rd(ST,   32'h0,         {pfx, "_status"});
    rd(MLO,  32'h0,         {pfx, "_mtime_hold"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int ps_exp[6];
    int ps_exp2[6];
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_acc_mode = WORD; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_reset_state("rst0");

    // Free-running count and first compare event at mtime == 10.
    wr(CHI, 32'h0);
    wr(CLO, 32'd10);
    wr(PS, 32'h0);
    wr(CTRL, 32'h3);
    for (int i = 0; i <= 12; i++) begin
      exp_irq(i >= 11, $sformatf("t1_irq_%0d", i));
      rd(MLO, i, $sformatf("t1_mtime_%0d", i));
    end
    rd(ST, 32'h1, "t1_status");                          // mtime 13

    // W1C, re-arm via compare writes, and W1C colliding with an event.
    wr(ST, 32'h1);                                       // 14
    exp_irq(1'b0, "t4_irq_cleared");
    rd(ST, 32'h0, "t4_status_cleared");                  // 15
    exp_irq(1'b0, "t4_irq_stays_low");
    rd(MLO, 32'd16, "t4_mtime16");                       // 16
    wr(CLO, 32'd1000);                                   // 17
    wr(CLO, 32'd20);                                     // 18
    rd(ST, 32'h0, "t4_pre_event19");                     // 19
    rd(ST, 32'h0, "t4_event_cycle20");                   // 20
    exp_irq(1'b1, "t4_irq_refire");
    rd(ST, 32'h1, "t4_status_refire");                   // 21
    wr(ST, 32'h1);                                       // 22
    wr(CLO, 32'd26);                                     // 23
    rd(ST, 32'h0, "t4_cleared24");                       // 24
    rd(MLO, 32'd25, "t4_mtime25");                       // 25
    wr(ST, 32'h1);                                       // 26: event and W1C together
    exp_irq(1'b1, "t4_set_wins_irq");
    rd(ST, 32'h1, "t4_set_wins");                        // 27

    // Non-word writes, out-of-window and misaligned accesses.
    cyc(1'b0, 1'b1, CTRL, 3'b000, 32'h0);
    rd(CTRL, 32'h3, "t5_sb_ignored");
    rd_raw(CTRL, 3'b000, 32'h3, 1'b1, "t5_byte_read_full_word");
    rd_raw(B + 32'h20, WORD, 32'h0, 1'b0, "t5_out_of_window");
    rd_raw(B + 32'h12, WORD, 32'h0, 1'b0, "t5_misaligned");
    wr(B + 32'h30, 32'h0);
    wr(B + 32'h12, 32'h0);
    rd(CTRL, 32'h3, "t5_bad_writes_ignored");

    // 64-bit carry and write-over-tick.
    wr(CTRL, 32'h0);
    wr(MHI, 32'h0);
    wr(MLO, 32'hFFFF_FFFE);
    wr(CTRL, 32'h1);
    rd(MLO, 32'hFFFF_FFFE, "t2_lo_fffe");
    rd(MLO, 32'hFFFF_FFFF, "t2_lo_ffff");
    rd(MHI, 32'h1, "t2_hi_carry");
    rd(MLO, 32'h1, "t2_lo_after_carry");
    wr(MLO, 32'h1234);
    rd(MLO, 32'h1234, "t2_write_over_tick");
    rd(MHI, 32'h1, "t2_hi_held");

    // Prescaler phase across a disable window.
    wr(CTRL, 32'h0);
    wr(MHI, 32'h0);
    wr(MLO, 32'h0);
    wr(PS, 32'd3);
    wr(CTRL, 32'h1);
    ps_exp = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) rd(MLO, ps_exp[i], $sformatf("t3_run_%0d", i));
    wr(CTRL, 32'h0);
    for (int i = 0; i < 3; i++) rd(MLO, 32'h1, $sformatf("t3_frozen_%0d", i));
    wr(CTRL, 32'h1);
    ps_exp2 = '{1, 2, 2, 2, 2, 3};
    for (int i = 0; i < 6; i++) rd(MLO, ps_exp2[i], $sformatf("t3_resume_%0d", i));
    wr(PS, 32'hABCD_1234);
    rd(PS, 32'h0000_1234, "t3_prescale_zext");

    // Reset in the middle of counting; the same-cycle write must not land.
    rst = 1'b1; wr_en = 1'b1; addr = CTRL; wdata = 32'h3;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    check_reset_state("rst1");

`ifdef MMIO_TIMER_AUTO_RELOAD_EN
    wr(CHI, 32'h0);
    wr(CLO, 32'd10);
    wr(PER, 32'd5);
    wr(CTRL, 32'h7);
    for (int i = 0; i <= 22; i++) begin
      exp_irq(i >= 11, $sformatf("t6_irq_%0d", i));
      rd(CLO, (i <= 10) ? 32'd10 : (i <= 15) ? 32'd15 : (i <= 20) ? 32'd20 : 32'd25,
         $sformatf("t6_cmp_%0d", i));
    end
    rd(CTRL, 32'h7, "t6_ctrl");
    rd(PER, 32'd5, "t6_period");
`else
    wr(CTRL, 32'h7);
    rd(CTRL, 32'h3, "t6_ctrl_bit2_absent");
    wr(PER, 32'd5);
    rd(PER, 32'h0, "t6_period_absent");
    wr(CHI, 32'h0);
    wr(CLO, 32'd2);
    for (int i = 0; i < 6; i++) rd(CLO, 32'd2, $sformatf("t6_cmp_static_%0d", i));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
Memory-mapped machine timer; the source end of the processor's `timer_interrupt` input.
- Responds to the same load/store bus the memory-writeback stage drives into data memory: `rd_en`, `wr_en`, `addr`, `mem_acc_mode`, `wdata` → `rdata`.
- Holds a 64-bit `mtime` with a programmable prescaler, a 64-bit `mtimecmp` and control/status registers.
- Raises a sticky, software-clearable timer interrupt when `mtime` reaches `mtimecmp`.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 32-byte register window; bits [4:0] are ignored.
- PRESCALE_W, 16, width of the PRESCALE register and the prescaler down-counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en  in  1  load request (MW stage)
- wr_en  in  1  store request (MW stage)
- addr  in  32  byte address
- mem_acc_mode  in  3  access size, RISC-V funct3 encoding (010 = word)
- wdata  in  32  store data
- rdata  out  32  load data, combinational
- sel  out  1  address hits the window (used by the writeback data mux)
- timer_interrupt  out  1  to the processor CSR trap input

Behaviour:
- Decode:
  - hit = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 0).
  - `sel` = hit & (rd_en | wr_en).
  - A write takes effect only if wr_en & hit & mem_acc_mode == 3'b010; other sizes are ignored, with no partial writes.
- Register map (word offsets):
  - 0x00 MTIME_LO, 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 `en`, bit1 `irq_en`, bit2 `auto_reload` (optional feature); other bits read 0
  - 0x14 PRESCALE: low PRESCALE_W bits, zero-extended on read
  - 0x18 STATUS: bit0 `pending`; write 1 clears, write 0 has no effect
  - 0x1C PERIOD (optional feature)
- Reads:
  - `rdata` = selected register when rd_en & hit, else 32'h0.
  - Zero latency: reads the current register values, before any same-cycle write.
  - Any read size returns the full word; the processor side extracts.
- Reset values:
  - mtime 0; mtimecmp 64'hFFFF_FFFF_FFFF_FFFF
  - CTRL 0, PRESCALE 0, PERIOD 0
  - prescaler counter 0, pending 0, cmp_prev 0
  - timer_interrupt 0
  - Reset mid-operation aborts everything; no write is taken in the reset cycle.
- Prescaler and tick:
  - While `en` = 1: if pscnt == 0, tick = 1 and pscnt <= PRESCALE; else pscnt <= pscnt - 1.
  - PRESCALE = 0 gives one tick per cycle; PRESCALE = N gives one tick every N+1 cycles.
  - `en` = 0: pscnt and mtime hold.
  - A write to PRESCALE also loads pscnt <= new value.
- mtime:
  - On tick, mtime <= mtime + 1 (64-bit). LO carry into HI happens in the same cycle; 2^64-1 wraps to 0.
  - A same-cycle software write to MTIME_LO or MTIME_HI wins. The written half takes wdata, the other half holds, and that tick's increment is lost.
- Compare:
  - cmp_now = (mtime >= mtimecmp), unsigned 64-bit, from registered values.
  - cmp_prev <= cmp_now every cycle.
  - Event = cmp_now & ~cmp_prev (rising edge); event → pending <= 1 at the next edge.
  - A W1C in the same cycle as an event: set wins.
  - A write to MTIMECMP_LO or MTIMECMP_HI does not clear pending, but re-arms the edge (the new value may fire again).
  - After software clears pending while cmp_now stays 1, pending stays 0.
- Output: timer_interrupt = pending & irq_en, driven only from registers (glitch-free). Latency: mtime == mtimecmp in cycle N → timer_interrupt high in cycle N+1.

Optional Feature:
MMIO_TIMER_AUTO_RELOAD_EN
- Defined:
  - CTRL bit2 and PERIOD (0x1C) are implemented.
  - On a compare event with `auto_reload` = 1: mtimecmp <= mtimecmp + {32'h0, PERIOD} (64-bit, wraps), in the same edge as the pending set.
  - A software write to MTIMECMP in that cycle wins over the reload.
- Undefined:
  - CTRL bit2 and 0x1C read 0; writes to them are ignored.
  - mtimecmp changes only by software write.

Test Plan:
1. Reset; write MTIMECMP_HI=0, MTIMECMP_LO=10, CTRL=3, PRESCALE=0 → MTIME_LO reads +1 per cycle; timer_interrupt rises one cycle after mtime==10; STATUS reads 1.
2. Write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFE, CTRL=1 → after 2 ticks MTIME_LO=0 and MTIME_HI=1; a write to MTIME_LO in the same cycle as a tick stores wdata exactly.
3. PRESCALE=3, CTRL=1 → mtime increments once every 4 cycles; CTRL=0 freezes mtime and pscnt; re-enable resumes the exact phase.
4. Following test 1, write STATUS=1 → pending and timer_interrupt go low and stay low while mtime ≥ 10; write MTIMECMP_LO=1000, then 20 → interrupt re-fires. W1C in the same cycle as an event → pending remains 1.
5. SB (mem_acc_mode=000) of 32'h3 to CTRL → CTRL unchanged; access at BASE_ADDR+0x20 or addr[1:0]=2 → sel=0 or ignored, rdata=0; rst asserted mid-count → all reset values next cycle.
6. With MMIO_TIMER_AUTO_RELOAD_EN: MTIMECMP=10, PERIOD=5, CTRL=7 → events at mtime 10, 15, 20; MTIMECMP reads 15 after the first event.
